// File: rtl/ds1302_schedmod.sv
// DS1302 command scheduler: periodic hour/min/sec reads and on-demand time writes,
// issued one command at a time to a control module with per-command timeout.
module ds1302_schedmod #(
  parameter logic [23:0] POLL_CYCLES = 24'd50_000,
  parameter logic [15:0] TIMEOUT     = 16'd60_000
) (
  input  logic       CLOCK,
  input  logic       RST_n,
  input  logic       iStart,
  input  logic [7:0] iHour,
  input  logic [7:0] iMin,
  input  logic [7:0] iSec,
  output logic [7:0] oCall,
  output logic [7:0] oData,
  input  logic       iDone,
  input  logic [7:0] iRdData,
  output logic [7:0] oHour,
  output logic [7:0] oMin,
  output logic [7:0] oSec,
  output logic       oUpdate,
  output logic       oBusy,
  output logic       oErr
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP, S_PUBLISH} state_t;

  state_t      state_q, state_d;
  logic        seq_wr_q, seq_wr_d;
  logic [2:0]  idx_q, idx_d;
  logic        pend_q, pend_d;
  logic        defer_q, defer_d;
  logic [7:0]  buf_h_q, buf_m_q, buf_s_q;
  logic [7:0]  buf_h_d, buf_m_d, buf_s_d;
  logic [7:0]  snap_h_q, snap_m_q, snap_s_q;
  logic [7:0]  snap_h_d, snap_m_d, snap_s_d;
  logic [7:0]  shd_h_q, shd_m_q, shd_s_q;
  logic [7:0]  shd_h_d, shd_m_d, shd_s_d;
  logic [7:0]  hour_q, min_q, sec_q;
  logic [7:0]  hour_d, min_d, sec_d;
  logic [23:0] poll_q, poll_d;
  logic [15:0] tmo_q, tmo_d;
  logic        upd_q, upd_d;
  logic        err_q, err_d;

  // An iStart arriving while idle is serviced on the same cycle, so it also
  // wins against a poll expiring on that cycle.
  logic       start_pend;
  logic       last_step;
  logic [7:0] call_w, call_r;

  assign start_pend = pend_q | iStart;
  assign last_step  = seq_wr_q ? (idx_q == 3'd4) : (idx_q == 3'd2);
  assign call_w     = 8'h80 >> idx_q;
  assign call_r     = 8'h04 >> idx_q;

  always_comb begin
    state_d  = state_q;
    seq_wr_d = seq_wr_q;
    idx_d    = idx_q;
    pend_d   = pend_q | iStart;
    defer_d  = defer_q;
    buf_h_d  = iStart ? iHour : buf_h_q;
    buf_m_d  = iStart ? iMin  : buf_m_q;
    buf_s_d  = iStart ? iSec  : buf_s_q;
    snap_h_d = snap_h_q;
    snap_m_d = snap_m_q;
    snap_s_d = snap_s_q;
    shd_h_d  = shd_h_q;
    shd_m_d  = shd_m_q;
    shd_s_d  = shd_s_q;
    hour_d   = hour_q;
    min_d    = min_q;
    sec_d    = sec_q;
    poll_d   = poll_q;
    tmo_d    = tmo_q;
    upd_d    = 1'b0;
    err_d    = 1'b0;
    oCall    = 8'h00;
    oData    = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (start_pend) begin
          state_d  = S_ISSUE;
          seq_wr_d = 1'b1;
          idx_d    = 3'd0;
          tmo_d    = 16'd0;
          pend_d   = 1'b0;
          defer_d  = (poll_q == 24'd0);
          snap_h_d = buf_h_d;
          snap_m_d = buf_m_d;
          snap_s_d = buf_s_d;
        end else if (poll_q == 24'd0) begin
          state_d  = S_ISSUE;
          seq_wr_d = 1'b0;
          idx_d    = 3'd0;
          tmo_d    = 16'd0;
        end else begin
          poll_d = poll_q - 24'd1;
        end
      end

      S_ISSUE: begin
        oCall = seq_wr_q ? call_w : call_r;
        if (seq_wr_q) begin
          case (idx_q)
            3'd1:    oData = snap_h_q;
            3'd2:    oData = snap_m_q;
            3'd3:    oData = snap_s_q;
            default: oData = 8'h00;
          endcase
        end
        if (iDone) begin
          state_d = S_GAP;
          if (!seq_wr_q) begin
            case (idx_q)
              3'd0:    shd_h_d = iRdData;
              3'd1:    shd_m_d = iRdData;
              default: shd_s_d = {1'b0, iRdData[6:0]};  // drop clock-halt flag
            endcase
          end
        end else if (tmo_q == TIMEOUT - 16'd1) begin
          // Abort: a failed write stays pending so it is retried from idle.
          state_d = S_IDLE;
          err_d   = 1'b1;
          poll_d  = POLL_CYCLES - 24'd1;
          defer_d = 1'b0;
          if (seq_wr_q) pend_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end

      S_GAP: begin
        if (!last_step) begin
          state_d = S_ISSUE;
          idx_d   = idx_q + 3'd1;
          tmo_d   = 16'd0;
        end else if (!seq_wr_q) begin
          state_d = S_PUBLISH;
        end else if (defer_q) begin
          state_d  = S_ISSUE;
          seq_wr_d = 1'b0;
          idx_d    = 3'd0;
          tmo_d    = 16'd0;
          defer_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
          poll_d  = POLL_CYCLES - 24'd1;
        end
      end

      S_PUBLISH: begin
        hour_d  = shd_h_q;
        min_d   = shd_m_q;
        sec_d   = shd_s_q;
        upd_d   = (shd_h_q != hour_q) || (shd_m_q != min_q) || (shd_s_q != sec_q);
        state_d = S_IDLE;
        poll_d  = POLL_CYCLES - 24'd1;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!RST_n) begin
      state_q  <= S_IDLE;
      seq_wr_q <= 1'b0;
      idx_q    <= 3'd0;
      pend_q   <= 1'b0;
      defer_q  <= 1'b0;
      buf_h_q  <= 8'h00;
      buf_m_q  <= 8'h00;
      buf_s_q  <= 8'h00;
      snap_h_q <= 8'h00;
      snap_m_q <= 8'h00;
      snap_s_q <= 8'h00;
      shd_h_q  <= 8'h00;
      shd_m_q  <= 8'h00;
      shd_s_q  <= 8'h00;
      hour_q   <= 8'h00;
      min_q    <= 8'h00;
      sec_q    <= 8'h00;
      poll_q   <= POLL_CYCLES - 24'd1;
      tmo_q    <= 16'd0;
      upd_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      seq_wr_q <= seq_wr_d;
      idx_q    <= idx_d;
      pend_q   <= pend_d;
      defer_q  <= defer_d;
      buf_h_q  <= buf_h_d;
      buf_m_q  <= buf_m_d;
      buf_s_q  <= buf_s_d;
      snap_h_q <= snap_h_d;
      snap_m_q <= snap_m_d;
      snap_s_q <= snap_s_d;
      shd_h_q  <= shd_h_d;
      shd_m_q  <= shd_m_d;
      shd_s_q  <= shd_s_d;
      hour_q   <= hour_d;
      min_q    <= min_d;
      sec_q    <= sec_d;
      poll_q   <= poll_d;
      tmo_q    <= tmo_d;
      upd_q    <= upd_d;
      err_q    <= err_d;
    end
  end

  assign oHour   = hour_q;
  assign oMin    = min_q;
  assign oSec    = sec_q;
  assign oUpdate = upd_q;
  assign oErr    = err_q;
  assign oBusy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_ds1302_schedmod.sv
// Bench for ds1302_schedmod: 3-cycle iDone responder plus a command scoreboard
// (expected oCall/oData pushed per scenario, popped as each command appears).
module tb_ds1302_schedmod;

  localparam int TMO = 30;

  logic       CLOCK, RST_n, iStart, iDone;
  logic [7:0] iHour, iMin, iSec, iRdData;
  logic [7:0] oCall, oData, oHour, oMin, oSec;
  logic       oUpdate, oBusy, oErr;

  ds1302_schedmod #(.POLL_CYCLES(24'd8), .TIMEOUT(16'd30)) dut (
    .CLOCK(CLOCK), .RST_n(RST_n), .iStart(iStart),
    .iHour(iHour), .iMin(iMin), .iSec(iSec),
    .oCall(oCall), .oData(oData), .iDone(iDone), .iRdData(iRdData),
    .oHour(oHour), .oMin(oMin), .oSec(oSec),
    .oUpdate(oUpdate), .oBusy(oBusy), .oErr(oErr)
  );

  typedef struct { logic [7:0] call; logic [7:0] data; bit chained; } exp_t;
  exp_t sbq[$];

  int total = 0, bad = 0;
  int cyc = 0, done_cyc = -10;
  int upd_cnt = 0, sec_wr_cnt = 0;
  bit withhold = 0;
  logic [7:0] rd_h = 8'h12, rd_m = 8'h34, rd_s = 8'h56;

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;
  always @(posedge CLOCK) cyc <= cyc + 1;

  // Responder: iDone in the third cycle a command has been visible.
  initial begin
    logic [7:0] rprev;
    int rcnt;
    rprev = 8'h00; rcnt = 0;
    forever begin
      @(negedge CLOCK);
      iDone = 1'b0;
      if (oCall != 8'h00 && rprev == 8'h00) rcnt = 1;
      else if (oCall != 8'h00) rcnt++;
      if (oCall != 8'h00 && rcnt == 3 && !withhold) begin
        iDone    = 1'b1;
        iRdData  = oCall[2] ? rd_h : oCall[1] ? rd_m : oCall[0] ? rd_s : 8'h00;
        done_cyc = cyc;
      end
      rprev = oCall;
    end
  end

  // Monitor: gap after every done, scoreboard pop on each new command.
  initial begin
    logic [7:0] mprev;
    exp_t e;
    mprev = 8'h00;
    forever begin
      @(negedge CLOCK);
      if (oUpdate) upd_cnt++;
      if (cyc == done_cyc + 1) begin
        total++;
        if (oCall !== 8'h00) begin
          bad++; $display("FAIL gap: oCall=%h required 00", oCall);
        end
      end
      if (oCall !== 8'h00 && mprev === 8'h00) begin
        if (oCall === 8'h10) sec_wr_cnt++;
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          total++;
          if (oCall !== e.call || oData !== e.data) begin
            bad++;
            $display("FAIL cmd: oCall=%h oData=%h required %h/%h", oCall, oData, e.call, e.data);
          end
          if (e.chained) begin
            total++;
            if (cyc != done_cyc + 2) begin
              bad++;
              $display("FAIL chain %h: start=%0d required %0d", oCall, cyc, done_cyc + 2);
            end
          end
        end else if (oCall[7:3] != 5'd0) begin
          total++; bad++;
          $display("FAIL unexpected write cmd: oCall=%h required none", oCall);
        end
      end
      mprev = oCall;
    end
  end

  function automatic void push(input logic [7:0] c, input logic [7:0] d, input bit ch);
    exp_t e;
    e.call = c; e.data = d; e.chained = ch;
    sbq.push_back(e);
  endfunction

  function automatic void push_wr(input logic [7:0] h, m, s);
    push(8'h80, 8'h00, 1'b0);
    push(8'h40, h, 1'b1);
    push(8'h20, m, 1'b1);
    push(8'h10, s, 1'b1);
    push(8'h08, 8'h00, 1'b1);
  endfunction

  function automatic void push_rd(input bit first_chained);
    push(8'h04, 8'h00, first_chained);
    push(8'h02, 8'h00, 1'b1);
    push(8'h01, 8'h00, 1'b1);
  endfunction

  // Returns at the negedge of the first post-reset cycle (poll counter = 7).
  task automatic do_reset;
    @(negedge CLOCK);
    RST_n = 1'b0; iStart = 1'b0; withhold = 0;
    @(negedge CLOCK);
    RST_n = 1'b1;
    sbq.delete();
  endtask

  task automatic pulse_start(input logic [7:0] h, m, s);
    iHour = h; iMin = m; iSec = s; iStart = 1'b1;
    @(negedge CLOCK);
    iStart = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((sbq.size() != 0 || oBusy) && n < 400) begin @(negedge CLOCK); n++; end
    total++;
    if (n >= 400) begin
      bad++; $display("FAIL %s drain: queued=%0d busy=%0b required 0/0", tag, sbq.size(), oBusy);
    end
    @(negedge CLOCK);
  endtask

  task automatic test_reset;
    do_reset();
    total++;
    if ({oCall, oData, oHour, oMin, oSec} !== 40'h0 || {oUpdate, oBusy, oErr} !== 3'b000) begin
      bad++;
      $display("FAIL reset: call=%h data=%h t=%h%h%h u/b/e=%b%b%b required all 0",
               oCall, oData, oHour, oMin, oSec, oUpdate, oBusy, oErr);
    end
  endtask

  task automatic test_poll_read;
    int n = 0, u0;
    do_reset();
    rd_h = 8'h12; rd_m = 8'h34; rd_s = 8'h56;
    u0 = upd_cnt;
    push_rd(1'b0);
    while (oCall == 8'h00 && n < 50) begin @(negedge CLOCK); n++; end
    total++;
    if (n != 8) begin bad++; $display("FAIL poll_delay: cycles=%0d required 8", n); end
    wait_idle("poll_read");
    total++;
    if ({oHour, oMin, oSec} !== 24'h123456) begin
      bad++; $display("FAIL poll_time: %h%h%h required 123456", oHour, oMin, oSec);
    end
    total++;
    if (upd_cnt - u0 != 1) begin bad++; $display("FAIL poll_upd: pulses=%0d required 1", upd_cnt - u0); end
  endtask

  task automatic test_write;
    int n = 0;
    bit busy_ok = 1;
    do_reset();
    push_wr(8'h23, 8'h59, 8'h58);
    push_rd(1'b0);
    @(negedge CLOCK);
    pulse_start(8'h23, 8'h59, 8'h58);
    while (oCall != 8'h80 && n < 20) begin @(negedge CLOCK); n++; end
    for (int i = 0; i < 20; i++) begin
      if (oBusy !== 1'b1) busy_ok = 0;
      @(negedge CLOCK);
    end
    total++;
    if (!busy_ok) begin bad++; $display("FAIL write_busy: dropped=1 required 0"); end
    wait_idle("write");
  endtask

  task automatic test_collision;
    do_reset();
    push_wr(8'h01, 8'h02, 8'h03);
    push_rd(1'b1);
    repeat (7) @(negedge CLOCK);
    pulse_start(8'h01, 8'h02, 8'h03);
    wait_idle("collision");
  endtask

  task automatic test_timeout;
    int n = 0, c, e;
    do_reset();
    withhold = 1;
    push(8'h80, 8'h00, 1'b0);
    push_wr(8'h11, 8'h22, 8'h33);
    push_rd(1'b0);
    @(negedge CLOCK);
    pulse_start(8'h11, 8'h22, 8'h33);
    while (oCall != 8'h80 && n < 20) begin @(negedge CLOCK); n++; end
    c = cyc; n = 0;
    while (!oErr && n < TMO + 20) begin @(negedge CLOCK); n++; end
    e = cyc;
    withhold = 0;
    total++;
    if (e - c != TMO) begin bad++; $display("FAIL err_time: delta=%0d required %0d", e - c, TMO); end
    total++;
    if (oCall !== 8'h00) begin bad++; $display("FAIL err_call: oCall=%h required 00", oCall); end
    @(negedge CLOCK);
    total++;
    if (oCall !== 8'h80 || oErr !== 1'b0) begin
      bad++; $display("FAIL retry: oCall=%h oErr=%b required 80/0", oCall, oErr);
    end
    wait_idle("timeout");
  endtask

  task automatic test_repeat_read;
    int u0;
    do_reset();
    rd_h = 8'h12; rd_m = 8'h34; rd_s = 8'h56;
    u0 = upd_cnt;
    push_rd(1'b0);
    push_rd(1'b0);
    wait_idle("repeat");
    total++;
    if (upd_cnt - u0 != 1) begin bad++; $display("FAIL repeat_upd: pulses=%0d required 1", upd_cnt - u0); end
    rd_s = 8'hD6;
    push_rd(1'b0);
    wait_idle("halt");
    total++;
    if (oSec !== 8'h56 || oHour !== 8'h12) begin
      bad++; $display("FAIL halt_mask: sec=%h hour=%h required 56/12", oSec, oHour);
    end
    total++;
    if (upd_cnt - u0 != 1) begin bad++; $display("FAIL halt_upd: pulses=%0d required 1", upd_cnt - u0); end
    rd_s = 8'h56;
  endtask

  task automatic test_mid_reset;
    int n = 0, s0;
    do_reset();
    push_rd(1'b0);
    wait_idle("pre_reset");
    total++;
    if (oHour !== 8'h12) begin bad++; $display("FAIL pre_reset: hour=%h required 12", oHour); end
    s0 = sec_wr_cnt;
    push(8'h80, 8'h00, 1'b0);
    push(8'h40, 8'h45, 1'b1);
    push(8'h20, 8'h30, 1'b1);
    pulse_start(8'h45, 8'h30, 8'h15);
    while (oCall != 8'h20 && n < 40) begin @(negedge CLOCK); n++; end
    RST_n = 1'b0;
    @(negedge CLOCK);
    total++;
    if ({oCall, oData, oHour, oMin, oSec} !== 40'h0 || {oUpdate, oBusy, oErr} !== 3'b000) begin
      bad++;
      $display("FAIL mid_reset: call=%h data=%h t=%h%h%h u/b/e=%b%b%b required all 0",
               oCall, oData, oHour, oMin, oSec, oUpdate, oBusy, oErr);
    end
    RST_n = 1'b1;
    sbq.delete();
    repeat (40) @(negedge CLOCK);
    total++;
    if (sec_wr_cnt != s0) begin bad++; $display("FAIL no_sec_write: count=%0d required %0d", sec_wr_cnt, s0); end
  endtask

  initial begin
    RST_n = 1'b0; iStart = 1'b0; iDone = 1'b0; iRdData = 8'h00;
    iHour = 8'h00; iMin = 8'h00; iSec = 8'h00;
    test_reset();
    test_poll_read();
    test_write();
    test_collision();
    test_timeout();
    test_repeat_read();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
